nb_serial_add: RTL and testbench

//  Parametrised multi-cycle integer adder/subtractor for the ALU datapath. It processes

---
 rtl/nb_serial_add.sv | 104 ++++++++++
 tb/tb_nb_serial_add.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nb_serial_add.sv
// Multi-cycle adder/subtractor: one SLICE-bit digit per clock, LSB first, carry held between
// slices. Handshake is start/in_ready in, done pulse out.
module nb_serial_add #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, out_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [SLICE-1:0] a_s, b_s;
  logic [SLICE:0]   sum_s;
  logic             accept, last, c_msb;
  int unsigned      base;

  assign in_ready = (state_q != StRun);
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign accept   = start && in_ready;
  assign last     = (cnt_q == CW'(NSLICE - 1));

  assign out      = out_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

  // Slice datapath: one SLICE-bit add, result merged into the partial result word.
  always_comb begin
    base  = 32'(cnt_q) * SLICE;
    a_s   = a_q[base +: SLICE];
    b_s   = b_q[base +: SLICE];
    sum_s = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
    res_d = res_q;
    res_d[base +: SLICE] = sum_s[SLICE-1:0];
    // Carry into the top bit of this slice; only meaningful on the last slice.
    c_msb = a_s[SLICE-1] ^ b_s[SLICE-1] ^ sum_s[SLICE-1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtract as a + ~b + ~cin, so cout=1 means no borrow.
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? ~cin : cin;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      res_q   <= res_d;
      carry_q <= sum_s[SLICE];
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        out_q  <= res_d;
        cout_q <= sum_s[SLICE];
        ovf_q  <= sum_s[SLICE] ^ c_msb;
      end
    end
  end

endmodule

// File: tb/tb_nb_serial_add.sv
// Directed bench for nb_serial_add: 16/4 instance plus 8/8 and 8/2 instances driven in
// parallel for the narrow-width reruns.
module tb_nb_serial_add;

  logic        clk, rst_n, start, cin, sub;
  logic [15:0] a, b;
  logic [7:0]  a8, b8;

  logic [15:0] out0;
  logic [7:0]  out1, out2;
  logic        rdy0, rdy1, rdy2, cout0, cout1, cout2, ovf0, ovf1, ovf2;
  logic        done0, done1, done2, busy0, busy1, busy2;

  int n_total = 0;
  int n_bad   = 0;

  nb_serial_add #(.WIDTH(16), .SLICE(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(rdy0), .a(a), .b(b), .cin(cin),
    .sub(sub), .out(out0), .cout(cout0), .overflow(ovf0), .done(done0), .busy(busy0)
  );

  nb_serial_add #(.WIDTH(8), .SLICE(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(rdy1), .a(a8), .b(b8), .cin(cin),
    .sub(sub), .out(out1), .cout(cout1), .overflow(ovf1), .done(done1), .busy(busy1)
  );

  nb_serial_add #(.WIDTH(8), .SLICE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(rdy2), .a(a8), .b(b8), .cin(cin),
    .sub(sub), .out(out2), .cout(cout2), .overflow(ovf2), .done(done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from idle; watch 12 edges past acceptance for each instance's done pulse.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [7:0] ia8, input logic [7:0] ib8, input logic icin,
                        input logic isub, input logic [15:0] e16, input logic ec16,
                        input logic eo16, input logic [7:0] e8, input logic ec8,
                        input logic eo8, input bit chk8);
    int lat0 = 0, lat1 = 0, lat2 = 0, np0 = 0, np1 = 0, np2 = 0;
    logic [15:0] o0 = '0;
    logic [7:0]  o1 = '0, o2 = '0;
    logic c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    a = ia; b = ib; a8 = ia8; b8 = ib8; cin = icin; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done0) begin
        np0++;
        if (lat0 == 0) begin lat0 = k; o0 = out0; c0 = cout0; v0 = ovf0; end
      end
      if (done1) begin
        np1++;
        if (lat1 == 0) begin lat1 = k; o1 = out1; c1 = cout1; v1 = ovf1; end
      end
      if (done2) begin
        np2++;
        if (lat2 == 0) begin lat2 = k; o2 = out2; c2 = cout2; v2 = ovf2; end
      end
    end
    check_val({tag, ".out"}, 32'(o0), 32'(e16));
    check_val({tag, ".cout"}, 32'(c0), 32'(ec16));
    check_val({tag, ".ovf"}, 32'(v0), 32'(eo16));
    check_val({tag, ".lat"}, 32'(lat0), 32'd4);
    check_val({tag, ".pulses"}, 32'(np0), 32'd1);
    if (chk8) begin
      check_val({tag, ".w8s8.out"}, 32'(o1), 32'(e8));
      check_val({tag, ".w8s8.cout"}, 32'(c1), 32'(ec8));
      check_val({tag, ".w8s8.ovf"}, 32'(v1), 32'(eo8));
      check_val({tag, ".w8s8.lat"}, 32'(lat1), 32'd1);
      check_val({tag, ".w8s8.pulses"}, 32'(np1), 32'd1);
      check_val({tag, ".w8s2.out"}, 32'(o2), 32'(e8));
      check_val({tag, ".w8s2.cout"}, 32'(c2), 32'(ec8));
      check_val({tag, ".w8s2.ovf"}, 32'(v2), 32'(eo8));
      check_val({tag, ".w8s2.lat"}, 32'(lat2), 32'd4);
      check_val({tag, ".w8s2.pulses"}, 32'(np2), 32'd1);
    end
  endtask

  initial begin
    int seen;
    int pos[3];
    rst_n = 1'b0; start = 1'b0; cin = 1'b0; sub = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    tick();
    tick();
    check_val("rst.out", 32'(out0), 32'd0);
    check_val("rst.cout", 32'(cout0), 32'd0);
    check_val("rst.ovf", 32'(ovf0), 32'd0);
    check_val("rst.done", 32'(done0), 32'd0);
    check_val("rst.busy", 32'(busy0), 32'd0);
    check_val("rst.ready", 32'(rdy0), 32'd1);
    check_val("rst.out8", 32'({out1, out2}), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("t1", 16'h0001, 16'h0001, 8'h01, 8'h01, 1'b1, 1'b0,
           16'h0003, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
    run_op("t2a", 16'hFFFF, 16'h0001, 8'hFF, 8'h01, 1'b0, 1'b0,
           16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("t2b", 16'hFFFF, 16'h0001, 8'hFF, 8'h01, 1'b1, 1'b0,
           16'h0001, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    run_op("t3", 16'h7FFF, 16'h0001, 8'h7F, 8'h01, 1'b0, 1'b0,
           16'h8000, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
    run_op("t4a", 16'h0005, 16'h0007, 8'h00, 8'h00, 1'b0, 1'b1,
           16'hFFFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("t4b", 16'h8000, 16'h0001, 8'h00, 8'h00, 1'b0, 1'b1,
           16'h7FFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    // Start and operand changes while running must not disturb the operation in flight.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    check_val("t5.busy", 32'(busy0), 32'd1);
    check_val("t5.ready", 32'(rdy0), 32'd0);
    check_val("t5.hold", 32'(out0), 32'h7FFF);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (done0) begin
        seen++;
        check_val("t5.lat", 32'(k), 32'd4);
        check_val("t5.out", 32'(out0), 32'h2345);
      end
    end
    check_val("t5.pulses", 32'(seen), 32'd1);

    // Start held high: back-to-back operations, done every NSLICE+1 edges.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
    seen = 0; pos = '{0, 0, 0};
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (done0) begin
        if (seen < 3) pos[seen] = k;
        seen++;
      end
    end
    start = 1'b0;
    check_val("t5.b2b.first", 32'(pos[0]), 32'd5);
    check_val("t5.b2b.second", 32'(pos[1]), 32'd10);
    check_val("t5.b2b.third", 32'(pos[2]), 32'd15);
    check_val("t5.b2b.out", 32'(out0), 32'h0003);
    for (int k = 0; k < 10; k++) tick();

    // Reset during slice 2 aborts the operation with no done pulse.
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_val("t6.rst.out", 32'(out0), 32'd0);
    check_val("t6.rst.busy", 32'(busy0), 32'd0);
    check_val("t6.rst.ready", 32'(rdy0), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done0) seen++;
    end
    check_val("t6.nodone", 32'(seen), 32'd0);
    check_val("t6.out", 32'(out0), 32'd0);
    run_op("t6", 16'h1234, 16'h1111, 8'h00, 8'h00, 1'b0, 1'b0,
           16'h2345, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
